// File: rtl/neural_layer_dense_if.sv
// Handshake and configuration bundle for one dense neural-network layer.
// slave faces the layer itself; master faces the upstream store/controller.
interface neural_layer_dense_if #(
  parameter int W     = 8,
  parameter int N_IN  = 2,
  parameter int N_OUT = 2
);
  localparam int AW    = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int DEPTH = N_OUT * (N_IN + 1);
  localparam int CAW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                 req;
  logic                 in_req;
  logic [AW-1:0]        in_addr;
  logic [W-1:0]         in_data;
  logic                 cfg_we;
  logic [CAW-1:0]       cfg_addr;
  logic [W-1:0]         cfg_data;
  logic                 busy;
  logic                 ack_layer;
  logic                 out_valid;
  logic [N_OUT*W-1:0]   out_data;

  modport slave (
    input  req, in_data, cfg_we, cfg_addr, cfg_data,
    output in_req, in_addr, busy, ack_layer, out_valid, out_data
  );

  modport master (
    output req, in_data, cfg_we, cfg_addr, cfg_data,
    input  in_req, in_addr, busy, ack_layer, out_valid, out_data
  );
endinterface

// File: rtl/neural_layer_dense.sv
// Fixed-point dense layer: N_OUT parallel lanes, each accumulating N_IN
// weighted inputs fetched serially, adding a bias, then saturating and
// applying the selected activation. Weights/biases live in a store that
// survives reset and is only writable while idle.
module neural_layer_dense #(
  parameter int W     = 8,
  parameter int F     = 4,
  parameter int N_IN  = 2,
  parameter int N_OUT = 2,
  parameter int ACT   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  neural_layer_dense_if.slave  bus
);
  localparam int AW    = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int DEPTH = N_OUT * (N_IN + 1);
  localparam int CAW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ACC   = 2 * W + $clog2(N_IN) + 1;

  localparam logic [AW-1:0]          LAST_IDX = AW'(N_IN - 1);
  localparam logic signed [ACC-1:0]  SAT_MAX  = $signed({{(ACC-W+1){1'b0}}, {(W-1){1'b1}}});
  localparam logic signed [ACC-1:0]  SAT_MIN  = $signed({{(ACC-W+1){1'b1}}, {(W-1){1'b0}}});
  localparam logic signed [W-1:0]    ONE_Q    = $signed({{(W-1){1'b0}}, 1'b1} << F);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DRAIN = 3'd2,
    ST_BIAS  = 3'd3,
    ST_ACT   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  state_t               state_r;
  logic                 in_req_r;
  logic [AW-1:0]        in_addr_r;
  logic                 busy_r;
  logic                 ack_r;
  logic                 out_valid_r;
  logic [N_OUT*W-1:0]   out_data_r;

  // Parameter store: entry o*(N_IN+1)+i is weight i of neuron o, i = N_IN is its bias.
  logic signed [W-1:0]  w_mem [DEPTH];

  // One-cycle-delayed view of the fetch: data for index smp_idx_r is on in_data now.
  logic                 smp_v_r;
  logic [AW-1:0]        smp_idx_r;
  logic signed [ACC-1:0] acc_r [N_OUT];

  logic                   start_s;
  logic                   cfg_wr_s;
  logic [CAW-1:0]         widx_s     [N_OUT];
  logic [CAW-1:0]         bidx_s     [N_OUT];
  logic signed [2*W-1:0]  prod_s     [N_OUT];
  logic signed [2*W-1:0]  prod_sh_s  [N_OUT];
  logic signed [ACC-1:0]  prod_ext_s [N_OUT];
  logic signed [ACC-1:0]  bias_ext_s [N_OUT];
  logic signed [W-1:0]    sat_s      [N_OUT];
  logic signed [W-1:0]    act_s      [N_OUT];
  logic [N_OUT*W-1:0]     act_vec_s;

  assign start_s  = (state_r == ST_IDLE) && bus.req;
  assign cfg_wr_s = (state_r == ST_IDLE) && bus.cfg_we && (32'(bus.cfg_addr) < DEPTH);

  assign bus.in_req    = in_req_r;
  assign bus.in_addr   = in_addr_r;
  assign bus.busy      = busy_r;
  assign bus.ack_layer = ack_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;

  // Per-lane product alignment, bias alignment, saturation and activation.
  always_comb begin
    act_vec_s = '0;
    for (int o = 0; o < N_OUT; o++) begin
      widx_s[o]     = CAW'(o * (N_IN + 1)) + CAW'(smp_idx_r);
      bidx_s[o]     = CAW'(o * (N_IN + 1) + N_IN);
      prod_s[o]     = (2*W)'($signed(bus.in_data)) * (2*W)'(w_mem[widx_s[o]]);
      prod_sh_s[o]  = prod_s[o] >>> F;
      prod_ext_s[o] = ACC'(prod_sh_s[o]);
      bias_ext_s[o] = ACC'(w_mem[bidx_s[o]]);
      if (acc_r[o] > SAT_MAX) begin
        sat_s[o] = $signed({1'b0, {(W-1){1'b1}}});
      end else if (acc_r[o] < SAT_MIN) begin
        sat_s[o] = $signed({1'b1, {(W-1){1'b0}}});
      end else begin
        sat_s[o] = acc_r[o][W-1:0];
      end
      case (ACT)
        32'd1:   act_s[o] = sat_s[o][W-1] ? '0 : sat_s[o];
        32'd2:   act_s[o] = sat_s[o][W-1] ? '0 : ONE_Q;
        default: act_s[o] = sat_s[o];
      endcase
      act_vec_s[o*W +: W] = act_s[o];
    end
  end

  // Sequencer: walks the fetch addresses, then drain/bias/activate/done, with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      in_req_r    <= 1'b0;
      in_addr_r   <= '0;
      busy_r      <= 1'b0;
      ack_r       <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          ack_r <= 1'b0;
          if (bus.req) begin
            state_r     <= ST_FETCH;
            in_req_r    <= 1'b1;
            in_addr_r   <= '0;
            busy_r      <= 1'b1;
            out_valid_r <= 1'b0;
          end else begin
            state_r  <= ST_IDLE;
            in_req_r <= 1'b0;
            busy_r   <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (in_addr_r == LAST_IDX) begin
            state_r   <= ST_DRAIN;
            in_req_r  <= 1'b0;
            in_addr_r <= '0;
          end else begin
            in_addr_r <= in_addr_r + AW'(1'b1);
          end
        end
        ST_DRAIN: state_r <= ST_BIAS;
        ST_BIAS:  state_r <= ST_ACT;
        ST_ACT: begin
          state_r     <= ST_DONE;
          ack_r       <= 1'b1;
          out_valid_r <= 1'b1;
          out_data_r  <= act_vec_s;
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          ack_r   <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r  <= ST_IDLE;
          in_req_r <= 1'b0;
          busy_r   <= 1'b0;
          ack_r    <= 1'b0;
        end
      endcase
    end
  end

  // Lane accumulators: clear on start, add each sampled product, then the bias.
  always_ff @(posedge clk) begin
    if (!rst) begin
      smp_v_r   <= 1'b0;
      smp_idx_r <= '0;
      for (int o = 0; o < N_OUT; o++) acc_r[o] <= '0;
    end else begin
      smp_v_r   <= (state_r == ST_FETCH);
      smp_idx_r <= in_addr_r;
      for (int o = 0; o < N_OUT; o++) begin
        if (start_s) begin
          acc_r[o] <= '0;
        end else if (smp_v_r) begin
          acc_r[o] <= acc_r[o] + prod_ext_s[o];
        end else if (state_r == ST_BIAS) begin
          acc_r[o] <= acc_r[o] + bias_ext_s[o];
        end else begin
          acc_r[o] <= acc_r[o];
        end
      end
    end
  end

  // Parameter store write port: idle-only, in-range, never cleared by reset.
  always_ff @(posedge clk) begin
    if (rst && cfg_wr_s) begin
      w_mem[bus.cfg_addr] <= bus.cfg_data;
    end
  end
endmodule

// File: tb/tb_neural_layer_dense.sv
// Directed bench for neural_layer_dense: three instances (identity, ReLU,
// step) share stimulus; a small upstream store model answers fetches.
module tb_neural_layer_dense;
  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic       cfg_we;
  logic [2:0] cfg_addr;
  logic [7:0] cfg_data;
  logic [7:0] in_data;
  logic [7:0] inp [2];
  int         vectors = 0;
  int         miscompares = 0;
  int         got;

  always #5 clk = ~clk;

  neural_layer_dense_if #(.W(8), .N_IN(2), .N_OUT(2)) ifc0 ();
  neural_layer_dense_if #(.W(8), .N_IN(2), .N_OUT(2)) ifc1 ();
  neural_layer_dense_if #(.W(8), .N_IN(2), .N_OUT(2)) ifc2 ();

  assign ifc0.req = req;  assign ifc0.cfg_we = cfg_we;  assign ifc0.cfg_addr = cfg_addr;
  assign ifc0.cfg_data = cfg_data;  assign ifc0.in_data = in_data;
  assign ifc1.req = req;  assign ifc1.cfg_we = cfg_we;  assign ifc1.cfg_addr = cfg_addr;
  assign ifc1.cfg_data = cfg_data;  assign ifc1.in_data = in_data;
  assign ifc2.req = req;  assign ifc2.cfg_we = cfg_we;  assign ifc2.cfg_addr = cfg_addr;
  assign ifc2.cfg_data = cfg_data;  assign ifc2.in_data = in_data;

  neural_layer_dense #(.W(8), .F(4), .N_IN(2), .N_OUT(2), .ACT(0)) dut0 (.clk(clk), .rst(rst), .bus(ifc0.slave));
  neural_layer_dense #(.W(8), .F(4), .N_IN(2), .N_OUT(2), .ACT(1)) dut1 (.clk(clk), .rst(rst), .bus(ifc1.slave));
  neural_layer_dense #(.W(8), .F(4), .N_IN(2), .N_OUT(2), .ACT(2)) dut2 (.clk(clk), .rst(rst), .bus(ifc2.slave));

  // Upstream activation store: one-cycle read latency after in_req.
  always @(posedge clk) begin
    if (ifc0.in_req) in_data <= inp[ifc0.in_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic load(input logic [7:0] w00, w01, b0, w10, w11, b1);
    cfg_write(3'd0, w00); cfg_write(3'd1, w01); cfg_write(3'd2, b0);
    cfg_write(3'd3, w10); cfg_write(3'd4, w11); cfg_write(3'd5, b1);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, ".busy"},      32'(ifc0.busy),      32'd0);
    check({tag, ".in_req"},    32'(ifc0.in_req),    32'd0);
    check({tag, ".in_addr"},   32'(ifc0.in_addr),   32'd0);
    check({tag, ".ack"},       32'(ifc0.ack_layer), 32'd0);
    check({tag, ".out_valid"}, 32'(ifc0.out_valid), 32'd0);
    check({tag, ".out_data"},  32'(ifc0.out_data),  32'd0);
  endtask

  // One request pulse; expects ack in the 6th cycle and the three activation results.
  task automatic run_pass(input string tag, input logic [15:0] e0, e1, e2);
    got = 0;
    @(negedge clk);
    req = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      req = 1'b0;
      if (k == 1) begin
        check({tag, ".valid_clr"}, 32'(ifc0.out_valid), 32'd0);
        check({tag, ".busy"},      32'(ifc0.busy),      32'd1);
      end
      if (ifc0.ack_layer) begin
        got = k;
        break;
      end
    end
    check({tag, ".latency"}, 32'(got), 32'd6);
    check({tag, ".out_id"},   32'(ifc0.out_data), 32'(e0));
    check({tag, ".out_relu"}, 32'(ifc1.out_data), 32'(e1));
    check({tag, ".out_step"}, 32'(ifc2.out_data), 32'(e2));
    check({tag, ".valid"},    32'(ifc0.out_valid), 32'd1);
    @(negedge clk);
    check({tag, ".ack_pulse"},  32'(ifc0.ack_layer), 32'd0);
    check({tag, ".valid_hold"}, 32'(ifc0.out_valid), 32'd1);
  endtask

  initial begin
    rst = 1'b0; req = 1'b0; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_data = 8'd0;
    inp[0] = 8'd0; inp[1] = 8'd0;
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b1;

    // n0 {12,-14} bias 1, n1 {-17,24} bias -3, inputs {16,32}
    inp[0] = 8'h10; inp[1] = 8'h20;
    load(8'h0C, 8'hF2, 8'h01, 8'hEF, 8'h18, 8'hFD);
    run_pass("basic", 16'h1CF1, 16'h1C00, 16'h1000);

    // Reset while fetching index 1
    @(negedge clk); req = 1'b1;
    @(negedge clk); req = 1'b0;
    check("midrst.in_req0",  32'(ifc0.in_req),  32'd1);
    check("midrst.in_addr0", 32'(ifc0.in_addr), 32'd0);
    @(negedge clk);
    check("midrst.in_addr1", 32'(ifc0.in_addr), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero("midrst");
    rst = 1'b1;
    run_pass("after_rst", 16'h1CF1, 16'h1C00, 16'h1000);

    // Reset wins over req and cfg_we in the same cycle
    @(negedge clk);
    rst = 1'b0; req = 1'b1; cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 8'h7F;
    @(negedge clk);
    check("rstprio.busy", 32'(ifc0.busy), 32'd0);
    rst = 1'b1; req = 1'b0; cfg_we = 1'b0;
    run_pass("rstprio", 16'h1CF1, 16'h1C00, 16'h1000);

    // Back-to-back passes with a config write attempted mid-pass
    @(negedge clk); req = 1'b1;
    got = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ifc0.ack_layer) begin got = k; break; end
    end
    check("b2b.first", 32'(got), 32'd6);
    got = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 2) begin cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 8'h7F; end
      if (k == 3) cfg_we = 1'b0;
      if (ifc0.ack_layer) begin got = k; break; end
    end
    check("b2b.period1", 32'(got), 32'd7);
    check("b2b.out1", 32'(ifc0.out_data), 32'h1CF1);
    got = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ifc0.ack_layer) begin got = k; break; end
    end
    check("b2b.period2", 32'(got), 32'd7);
    check("b2b.out2", 32'(ifc0.out_data), 32'h1CF1);
    req = 1'b0;
    @(negedge clk);
    check("b2b.idle_busy", 32'(ifc0.busy), 32'd0);
    repeat (3) @(negedge clk);
    check("b2b.hold_valid", 32'(ifc0.out_valid), 32'd1);
    check("b2b.hold_data",  32'(ifc0.out_data),  32'h1CF1);

    // Out-of-range store addresses
    cfg_write(3'd6, 8'h55);
    cfg_write(3'd7, 8'hAA);
    run_pass("oor", 16'h1CF1, 16'h1C00, 16'h1000);

    // Saturation both directions
    inp[0] = 8'h7F; inp[1] = 8'h7F;
    load(8'h7F, 8'h7F, 8'h00, 8'h7F, 8'h7F, 8'h00);
    run_pass("sat_pos", 16'h7F7F, 16'h7F7F, 16'h1010);
    load(8'h80, 8'h80, 8'h00, 8'h80, 8'h80, 8'h00);
    run_pass("sat_neg", 16'h8080, 16'h0000, 16'h0000);

    // Floor rounding of 1 * -1 >>> 4
    inp[0] = 8'h01; inp[1] = 8'h05;
    load(8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    run_pass("floor", 16'h00FF, 16'h0000, 16'h1000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
